lns_dot_sequencer: RTL and testbench
====================================

Name: lns_dot_sequencer

Overview:
Sequences one log_mac instance through complete dot products of a programmed length N. It sits between an operand stream source and the log_mac.
- On start it clears the accumulator, forwards exactly N operand pairs, and discards the N-1 partial accumulations the MAC returns.
- It captures the Nth accumulation and presents it on a valid/enable result port, then returns to idle.

Parameters:
IN_BITS, 8, operand magnitude width; operand buses are IN_BITS+1 bits.
OUT_BITS, 16, accumulator magnitude width; result buses are OUT_BITS+1 bits.
LEN_BITS, 8, width of the length register and counters; N ranges 1..2^LEN_BITS-1.

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  request a dot product; sampled in IDLE only
abort  input  1  synchronous abort of the running dot product
cfg_len  input  LEN_BITS  N, latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on the result handshake
op_valid  input  1  operand pair valid
op_enable  output  1  sequencer accepts an operand pair
op_x, op_y  input  IN_BITS+1 each  operands
op_x_nat_sign, op_y_nat_sign  input  1 each  operand signs
mac_clr  output  1  accumulator clear to log_mac
mac_data_in_valid  output  1  to log_mac
mac_data_in_enable  input  1  from log_mac
mac_x, mac_y  output  IN_BITS+1 each  operands to log_mac
mac_x_nat_sign, mac_y_nat_sign  output  1 each  signs to log_mac
mac_data_out_valid  input  1  log_mac accumulation beat valid
mac_data_out_enable  output  1  to log_mac; constant 1
mac_accum  input  OUT_BITS+1  log_mac accumulator value
mac_accum_nat_sign  input  1  log_mac accumulator sign
res_valid  output  1  result available
res_enable  input  1  result consumer ready
res_data  output  OUT_BITS+1  captured Nth accumulation
res_nat_sign  output  1  captured sign

Behaviour:
- Reset (async, rstn=0):
  - State is IDLE; len_r, iss_cnt and ret_cnt are 0.
  - res_data is 0, res_nat_sign 0, res_valid 0.
  - mac_clr, done, busy, op_enable and mac_data_in_valid are 0.
  - Reset mid-operation drops all progress immediately.
- Operand path is combinational pass-through: mac_x=op_x, mac_y=op_y, signs likewise.
- op_enable = mac_data_in_enable & (state==STREAM).
- mac_data_in_valid = op_valid & (state==STREAM).
- An issue occurs on op_valid & op_enable.
- A return occurs on mac_data_out_valid. It is always consumed, because mac_data_out_enable=1.
- Returns in IDLE, CLEAR or OUTPUT are discarded and not counted.
- IDLE:
  - start & cfg_len!=0: latch len_r=cfg_len, go CLEAR.
  - start with cfg_len==0: ignored, stay IDLE.
- CLEAR:
  - mac_clr=1 for exactly this one cycle.
  - iss_cnt and ret_cnt are set to 0; next state STREAM.
- STREAM:
  - Each issue increments iss_cnt; each return increments ret_cnt. Both may occur in the same cycle.
  - When an issue makes iss_cnt==len_r, go DRAIN. op_enable is 0 from the next cycle, so there is never an (N+1)th issue.
- DRAIN:
  - Returns keep incrementing ret_cnt.
  - The return that makes ret_cnt==len_r captures mac_accum into res_data and mac_accum_nat_sign into res_nat_sign, then goes OUTPUT.
  - The Nth return arriving while still in STREAM is impossible, because log_mac has at least one cycle of latency.
- OUTPUT:
  - res_valid=1 with res_data and res_nat_sign stable.
  - On res_enable: done=1 for that cycle, res_valid=0 next cycle, go IDLE.
  - A start in the handshake cycle is not accepted; start is sampled in IDLE the following cycle.
- abort, in any state other than IDLE:
  - Next state IDLE; counters cleared.
  - mac_clr=1 for one cycle on the abort cycle.
  - No done pulse; res_valid forced 0; res_data retains its last captured value.
  - abort in IDLE has no effect.
  - abort together with res_enable in OUTPUT: abort wins, no done pulse.
- Counter wrap: not possible, since N ≤ 2^LEN_BITS-1 and the counters stop at len_r.
- busy = (state != IDLE).
- start while busy: ignored.

Test Plan:
- Len 3, back-to-back operands, MAC stub returns accum 17'h00011, 17'h00022, 17'h00033 with sign 1 → mac_clr pulses once before the first issue; exactly 3 issues; res_data=17'h00033, res_nat_sign=1; done pulses on res_enable.
- Len 1 with res_enable held 0 for 5 cycles → res_valid stays 1 and res_data stable for 5 cycles; done pulses in the handshake cycle; busy=0 next cycle.
- Len 4, mac_data_in_enable toggling 1,0,1,0 and op_valid gapped → iss_cnt reaches 4 with no 5th issue; op_enable=0 whenever mac_data_in_enable=0; result is the 4th returned value.
- Abort in STREAM after 2 of 5 issues → IDLE next cycle, one mac_clr pulse, no done, res_valid=0. A new start with len 2 then completes normally.
- cfg_len=0 with start, and start while busy → both ignored: no state change, no mac_clr.
- rstn low during DRAIN of len 3 → all outputs 0 immediately; after release a len 2 job completes correctly.

Source files
------------

// File: rtl/lns_dot_sequencer.sv
// rtl/lns_dot_sequencer.sv - sequences one log_mac through N-term dot products
module lns_dot_sequencer #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 16,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_BITS-1:0] cfg_len,
  output logic                busy,
  output logic                done,
  input  logic                op_valid,
  output logic                op_enable,
  input  logic [IN_BITS:0]    op_x,
  input  logic [IN_BITS:0]    op_y,
  input  logic                op_x_nat_sign,
  input  logic                op_y_nat_sign,
  output logic                mac_clr,
  output logic                mac_data_in_valid,
  input  logic                mac_data_in_enable,
  output logic [IN_BITS:0]    mac_x,
  output logic [IN_BITS:0]    mac_y,
  output logic                mac_x_nat_sign,
  output logic                mac_y_nat_sign,
  input  logic                mac_data_out_valid,
  output logic                mac_data_out_enable,
  input  logic [OUT_BITS:0]   mac_accum,
  input  logic                mac_accum_nat_sign,
  output logic                res_valid,
  input  logic                res_enable,
  output logic [OUT_BITS:0]   res_data,
  output logic                res_nat_sign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  localparam logic [LEN_BITS-1:0] CNT_ONE = LEN_BITS'(1);

  state_t              state, state_nxt;
  logic [LEN_BITS-1:0] len_r, len_nxt;
  logic [LEN_BITS-1:0] iss_cnt, iss_cnt_nxt, iss_inc;
  logic [LEN_BITS-1:0] ret_cnt, ret_cnt_nxt, ret_inc;
  logic [OUT_BITS:0]   res_data_nxt;
  logic                res_sign_nxt;
  logic                issue;

  assign mac_x               = op_x;
  assign mac_y               = op_y;
  assign mac_x_nat_sign      = op_x_nat_sign;
  assign mac_y_nat_sign      = op_y_nat_sign;
  assign mac_data_out_enable = 1'b1;

  assign busy              = (state != S_IDLE);
  assign op_enable         = mac_data_in_enable & (state == S_STREAM);
  assign mac_data_in_valid = op_valid & (state == S_STREAM);
  assign res_valid         = (state == S_OUTPUT);

  assign issue   = op_valid & op_enable;
  assign iss_inc = iss_cnt + CNT_ONE;
  assign ret_inc = ret_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      len_r        <= '0;
      iss_cnt      <= '0;
      ret_cnt      <= '0;
      res_data     <= '0;
      res_nat_sign <= 1'b0;
    end else begin
      state        <= state_nxt;
      len_r        <= len_nxt;
      iss_cnt      <= iss_cnt_nxt;
      ret_cnt      <= ret_cnt_nxt;
      res_data     <= res_data_nxt;
      res_nat_sign <= res_sign_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_r;
    iss_cnt_nxt  = iss_cnt;
    ret_cnt_nxt  = ret_cnt;
    res_data_nxt = res_data;
    res_sign_nxt = res_nat_sign;
    mac_clr      = 1'b0;
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && (cfg_len != '0)) begin
          len_nxt   = cfg_len;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr     = 1'b1;
        iss_cnt_nxt = '0;
        ret_cnt_nxt = '0;
        state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        // log_mac latency guarantees the Nth return cannot land here
        if (issue) begin
          iss_cnt_nxt = iss_inc;
          if (iss_inc == len_r) state_nxt = S_DRAIN;
        end
        if (mac_data_out_valid) ret_cnt_nxt = ret_inc;
      end
      S_DRAIN: begin
        if (mac_data_out_valid) begin
          ret_cnt_nxt = ret_inc;
          if (ret_inc == len_r) begin
            res_data_nxt = mac_accum;
            res_sign_nxt = mac_accum_nat_sign;
            state_nxt    = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (res_enable) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // abort overrides everything, including a same-cycle capture or handshake
    if (abort && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      iss_cnt_nxt  = '0;
      ret_cnt_nxt  = '0;
      res_data_nxt = res_data;
      res_sign_nxt = res_nat_sign;
      mac_clr      = 1'b1;
      done         = 1'b0;
    end
  end

endmodule

// File: tb/tb_lns_dot_sequencer.sv
// tb/tb_lns_dot_sequencer.sv - scoreboard bench for lns_dot_sequencer
module tb_lns_dot_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort;
  logic [7:0]  cfg_len;
  logic        busy, done;
  logic        op_valid, op_enable;
  logic [8:0]  op_x, op_y;
  logic        op_x_nat_sign, op_y_nat_sign;
  logic        mac_clr, mac_data_in_valid, mac_data_in_enable;
  logic [8:0]  mac_x, mac_y;
  logic        mac_x_nat_sign, mac_y_nat_sign;
  logic        mac_data_out_valid, mac_data_out_enable;
  logic [16:0] mac_accum;
  logic        mac_accum_nat_sign;
  logic        res_valid, res_enable;
  logic [16:0] res_data;
  logic        res_nat_sign;

  lns_dot_sequencer #(.IN_BITS(8), .OUT_BITS(16), .LEN_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_len(cfg_len),
    .busy(busy), .done(done), .op_valid(op_valid), .op_enable(op_enable),
    .op_x(op_x), .op_y(op_y), .op_x_nat_sign(op_x_nat_sign), .op_y_nat_sign(op_y_nat_sign),
    .mac_clr(mac_clr), .mac_data_in_valid(mac_data_in_valid),
    .mac_data_in_enable(mac_data_in_enable), .mac_x(mac_x), .mac_y(mac_y),
    .mac_x_nat_sign(mac_x_nat_sign), .mac_y_nat_sign(mac_y_nat_sign),
    .mac_data_out_valid(mac_data_out_valid), .mac_data_out_enable(mac_data_out_enable),
    .mac_accum(mac_accum), .mac_accum_nat_sign(mac_accum_nat_sign),
    .res_valid(res_valid), .res_enable(res_enable), .res_data(res_data),
    .res_nat_sign(res_nat_sign)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          clr_cnt = 0;
  int          iss_obs = 0;
  int          done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [16:0] ret_tab[0:7];
  logic        stub_sign;
  int          ret_idx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // log_mac stub: one-cycle latency, returns the next table entry per issue
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mac_data_out_valid <= 1'b0;
      mac_accum          <= '0;
      mac_accum_nat_sign <= 1'b0;
      ret_idx            <= 0;
    end else begin
      if (mac_clr) ret_idx <= 0;
      if (mac_data_in_valid && mac_data_in_enable) begin
        mac_data_out_valid <= 1'b1;
        mac_accum          <= ret_tab[ret_idx[2:0]];
        mac_accum_nat_sign <= stub_sign;
        if (!mac_clr) ret_idx <= ret_idx + 1;
      end else begin
        mac_data_out_valid <= 1'b0;
      end
    end
  end

  // monitor: samples on the falling edge, pops the scoreboard on each result handshake
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (mac_clr) clr_cnt++;
        if (mac_data_in_valid && mac_data_in_enable) iss_obs++;
        if (done) done_cnt++;
        if (busy && !mac_data_in_enable) check("op_en_gate", op_enable, 0);
        if (res_valid && res_enable && !abort) begin
          check("done_on_hs", done, 1);
          check("res_q_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_data", res_data, e[16:0]);
            check("res_sign", res_nat_sign, e[17]);
          end
        end else if (done) begin
          check("done_spurious", done, 0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    cfg_len = 8'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check({nm, "_idle"}, busy, 0);
  endtask

  task automatic wait_issues(input int base, input int n, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (iss_obs - base >= n) break;
      tick();
    end
    check({nm, "_issues"}, iss_obs - base, n);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_res_valid"}, res_valid, 0);
    check({nm, "_res_data"}, res_data, 0);
    check({nm, "_res_sign"}, res_nat_sign, 0);
    check({nm, "_mac_clr"}, mac_clr, 0);
    check({nm, "_op_enable"}, op_enable, 0);
    check({nm, "_in_valid"}, mac_data_in_valid, 0);
  endtask

  initial begin
    int clr0, iss0, done0;
    rstn = 1'b0; start = 0; abort = 0; cfg_len = 0;
    op_valid = 0; op_x = 9'h055; op_y = 9'h1A3; op_x_nat_sign = 1; op_y_nat_sign = 0;
    mac_data_in_enable = 1; res_enable = 0; stub_sign = 0;
    for (int i = 0; i < 8; i++) ret_tab[i] = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("pass_x", mac_x, 9'h055);
    check("pass_ysign", mac_y_nat_sign, 0);
    check("out_enable", mac_data_out_enable, 1);
    rstn = 1'b1;
    tick();

    // len 3 back to back
    ret_tab[0] = 17'h00011; ret_tab[1] = 17'h00022; ret_tab[2] = 17'h00033; stub_sign = 1;
    exp_q.push_back({1'b1, 17'h00033});
    clr0 = clr_cnt; iss0 = iss_obs; done0 = done_cnt;
    op_valid = 1; res_enable = 1;
    start_job(3);
    check("t1_busy", busy, 1);
    wait_idle("t1");
    op_valid = 0;
    check("t1_clr", clr_cnt - clr0, 1);
    check("t1_iss", iss_obs - iss0, 3);
    check("t1_done", done_cnt - done0, 1);

    // len 1 with held-off consumer
    ret_tab[0] = 17'h1ABCD; stub_sign = 0;
    exp_q.push_back({1'b0, 17'h1ABCD});
    done0 = done_cnt;
    res_enable = 0; op_valid = 1;
    start_job(1);
    for (int i = 0; i < 50; i++) begin
      if (res_valid) break;
      tick();
    end
    op_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", res_valid, 1);
      check("t2_hold_data", res_data, 17'h1ABCD);
      tick();
    end
    check("t2_no_done_yet", done_cnt - done0, 0);
    res_enable = 1;
    tick();
    check("t2_busy_after", busy, 0);
    check("t2_valid_after", res_valid, 0);
    check("t2_done", done_cnt - done0, 1);

    // len 4 with toggling ready and gapped operands
    ret_tab[0] = 17'h00100; ret_tab[1] = 17'h00200; ret_tab[2] = 17'h00300;
    ret_tab[3] = 17'h0F00F; ret_tab[4] = 17'h1FFFF; stub_sign = 1;
    exp_q.push_back({1'b1, 17'h0F00F});
    iss0 = iss_obs;
    start_job(4);
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      mac_data_in_enable = (c % 2 == 0);
      op_valid = (c % 3 != 1);
      tick();
    end
    mac_data_in_enable = 1; op_valid = 0;
    check("t3_idle", busy, 0);
    check("t3_iss", iss_obs - iss0, 4);

    // abort in STREAM after 2 of 5 issues
    for (int i = 0; i < 8; i++) ret_tab[i] = 17'(i + 1);
    iss0 = iss_obs;
    op_valid = 1;
    start_job(5);
    wait_issues(iss0, 2, "t4");
    op_valid = 0; abort = 1;
    clr0 = clr_cnt; done0 = done_cnt;
    tick();
    abort = 0;
    check("t4_busy", busy, 0);
    check("t4_res_valid", res_valid, 0);
    tick();
    check("t4_clr", clr_cnt - clr0, 1);
    check("t4_done", done_cnt - done0, 0);
    check("t4_iss_total", iss_obs - iss0, 2);
    check("t4_res_kept", res_data, 17'h0F00F);
    ret_tab[0] = 17'h00101; ret_tab[1] = 17'h00202; stub_sign = 0;
    exp_q.push_back({1'b0, 17'h00202});
    op_valid = 1;
    start_job(2);
    wait_idle("t4b");
    op_valid = 0;

    // start with length 0, then start while busy
    clr0 = clr_cnt;
    start_job(0);
    tick();
    check("t5_len0_busy", busy, 0);
    check("t5_len0_clr", clr_cnt - clr0, 0);
    ret_tab[0] = 17'h00003; ret_tab[1] = 17'h00007; stub_sign = 1;
    exp_q.push_back({1'b1, 17'h00007});
    clr0 = clr_cnt; iss0 = iss_obs;
    start_job(2);
    tick();
    cfg_len = 8'd7; start = 1;
    tick();
    start = 0; op_valid = 1;
    wait_idle("t5");
    op_valid = 0;
    check("t5_clr", clr_cnt - clr0, 1);
    check("t5_iss", iss_obs - iss0, 2);

    // reset during DRAIN, then a clean len 2 job
    ret_tab[0] = 17'h00010; ret_tab[1] = 17'h00020; ret_tab[2] = 17'h00030;
    iss0 = iss_obs;
    op_valid = 1;
    start_job(3);
    wait_issues(iss0, 3, "t6");
    op_valid = 0;
    check("t6_in_drain", busy, 1);
    rstn = 0;
    #1;
    check_idle_outputs("t6_rst");
    tick();
    rstn = 1;
    tick();
    ret_tab[0] = 17'h00444; ret_tab[1] = 17'h1C0DE; stub_sign = 0;
    exp_q.push_back({1'b0, 17'h1C0DE});
    done0 = done_cnt;
    op_valid = 1;
    start_job(2);
    wait_idle("t6b");
    op_valid = 0;
    check("t6_done", done_cnt - done0, 1);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
